apb_arb_master: RTL

Two-port APB master and round-robin arbiter that shares the single APB peripheral bus (LED/SW1/SW2/SEG window at 0x2000_0000) between two requesters, e.g. core data port and debug/DMA port. The block accepts simple request/grant transactions, sequences the APB SETUP and ACCESS phases, and returns a one-cycle completion pulse with read data and an error flag. A timeout terminates any ACCESS phase the slave never completes.

---
 rtl/apb_arb_master_if.sv | 50 +++++
 rtl/apb_arb_master.sv | 133 +++++++++++++
 2 files changed

// File: rtl/apb_arb_master_if.sv
// rtl/apb_arb_master_if.sv - two requester ports plus the shared APB bus of apb_arb_master
interface apb_arb_master_if;
    logic        m0_req;
    logic [31:0] m0_addr;
    logic        m0_write;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_strb;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m0_err;

    logic        m1_req;
    logic [31:0] m1_addr;
    logic        m1_write;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_strb;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic        m1_err;

    logic [31:0] Paddr;
    logic        Pwrite;
    logic        Psel;
    logic        Penable;
    logic [31:0] Pwdata;
    logic [3:0]  Pstrb;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;

    modport master (
        input  m0_req, m0_addr, m0_write, m0_wdata, m0_strb,
        output m0_gnt, m0_rvalid, m0_rdata, m0_err,
        input  m1_req, m1_addr, m1_write, m1_wdata, m1_strb,
        output m1_gnt, m1_rvalid, m1_rdata, m1_err,
        output Paddr, Pwrite, Psel, Penable, Pwdata, Pstrb,
        input  Prdata, Pready, Pslverr
    );

    modport slave (
        output m0_req, m0_addr, m0_write, m0_wdata, m0_strb,
        input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
        output m1_req, m1_addr, m1_write, m1_wdata, m1_strb,
        input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
        input  Paddr, Pwrite, Psel, Penable, Pwdata, Pstrb,
        output Prdata, Pready, Pslverr
    );
endinterface

// File: rtl/apb_arb_master.sv
// rtl/apb_arb_master.sv - round-robin arbiter sharing one APB bus between two requesters
// Sequences SETUP/ACCESS, returns a one-cycle completion pulse, and times out stalled slaves.
module apb_arb_master #(
    parameter int TIMEOUT = 16
) (
    input  logic              Pclk,
    input  logic              Prst,
    apb_arb_master_if.master  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      paddr_q, paddr_d;
    logic             pwrite_q, pwrite_d;
    logic [31:0]      pwdata_q, pwdata_d;
    logic [3:0]       pstrb_q, pstrb_d;
    logic             rvalid0_q, rvalid0_d;
    logic             rvalid1_q, rvalid1_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic             gnt0, gnt1;

    // On a tie the port that did not win last time gets the bus.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE && !Prst) begin
            gnt0 = bus.m0_req && (!bus.m1_req || last_q);
            gnt1 = bus.m1_req && (!bus.m0_req || !last_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    owner_d  = gnt1;
                    last_d   = gnt1;
                    paddr_d  = gnt1 ? bus.m1_addr  : bus.m0_addr;
                    pwrite_d = gnt1 ? bus.m1_write : bus.m0_write;
                    pwdata_d = gnt1 ? bus.m1_wdata : bus.m0_wdata;
                    pstrb_d  = gnt1 ? (bus.m1_write ? bus.m1_strb : 4'b0000)
                                    : (bus.m0_write ? bus.m0_strb : 4'b0000);
                    cnt_d    = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (bus.Pready) begin
                    rdata_d   = pwrite_q ? 32'h0 : bus.Prdata;
                    err_d     = bus.Pslverr;
                    rvalid0_d = !owner_q;
                    rvalid1_d = owner_q;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        rdata_d   = 32'hFFFF_FFFF;
                        err_d     = 1'b1;
                        rvalid0_d = !owner_q;
                        rvalid1_d = owner_q;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Pclk) begin
        if (Prst) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rvalid = rvalid0_q;
    assign bus.m1_rvalid = rvalid1_q;
    assign bus.m0_rdata  = rdata_q;
    assign bus.m1_rdata  = rdata_q;
    assign bus.m0_err    = err_q;
    assign bus.m1_err    = err_q;
    assign bus.Psel      = (state_q != IDLE);
    assign bus.Penable   = (state_q == ACCESS);
    assign bus.Paddr     = paddr_q;
    assign bus.Pwrite    = pwrite_q;
    assign bus.Pwdata    = pwdata_q;
    assign bus.Pstrb     = pstrb_q;
endmodule
